// File: rtl/adder_pkg.sv
// Shared configuration defaults and segment sizing for the pipelined carry-select adder.
package adder_pkg;

  localparam int ADDER_DEF_WIDTH  = 32;
  localparam int ADDER_DEF_STAGES = 4;

  // Bits resolved per pipeline stage; falls back to the full width when stages is invalid.
  function automatic int seg_bits(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction

  function automatic bit adder_cfg_ok(input int width, input int stages);
    return (stages >= 1) && (width >= stages) && (width % stages == 0);
  endfunction

endpackage

// File: rtl/csa_segment.sv
// Combinational carry-select segment: two speculative ripple sums, picked by the incoming carry.
module csa_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_cin,
  output logic [SEG-1:0] o_sum,
  output logic           o_cout
);

  logic [SEG:0] w_sum0;
  logic [SEG:0] w_sum1;

  assign w_sum0 = {1'b0, i_a} + {1'b0, i_b};
  assign w_sum1 = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, 1'b1};

  assign {o_cout, o_sum} = i_cin ? w_sum1 : w_sum0;

endmodule

// File: rtl/pipelined_csa_adder.sv
// Pipelined carry-select adder, one SEG-bit segment per stage, valid/ready on both sides.
// Define ADDER_SAT_EN to clamp the sum to the signed range on overflow.
module pipelined_csa_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADDER_DEF_WIDTH,
  parameter int STAGES = ADDER_DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = seg_bits(WIDTH, STAGES);

  if (!adder_cfg_ok(WIDTH, STAGES)) begin : g_param_check
    $error("pipelined_csa_adder: WIDTH must be a positive multiple of STAGES");
  end

  logic w_advance;
  logic [WIDTH-1:0] w_raw_sum;
  logic [WIDTH-1:0] w_final_sum;
  logic w_raw_cout;
  logic w_raw_ovf;
  logic w_a_msb;
  logic w_b_msb;
  logic w_last_vin;

  logic [WIDTH-1:0] r_sum;
  logic r_cout;
  logic r_ovf;

  // Whole pipeline moves together; a full output register freezes every stage.
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SEG;
    localparam int UPW = WIDTH - LO;

    logic [UPW-1:0]    w_a_up;
    logic [UPW-1:0]    w_b_up;
    logic              w_cin;
    logic              w_vin;
    logic [SEG-1:0]    w_seg_sum;
    logic              w_seg_cout;
    logic [LO+SEG-1:0] w_sum_acc;
    logic              r_v;

    csa_segment #(.SEG(SEG)) u_seg (
      .i_a    (w_a_up[SEG-1:0]),
      .i_b    (w_b_up[SEG-1:0]),
      .i_cin  (w_cin),
      .o_sum  (w_seg_sum),
      .o_cout (w_seg_cout)
    );

    if (k == 0) begin : g_src
      assign w_a_up    = a;
      assign w_b_up    = b;
      assign w_cin     = cin;
      assign w_vin     = in_valid;
      assign w_sum_acc = w_seg_sum;
    end else begin : g_src
      assign w_a_up    = g_stage[k-1].g_reg.r_a_up;
      assign w_b_up    = g_stage[k-1].g_reg.r_b_up;
      assign w_cin     = g_stage[k-1].g_reg.r_c;
      assign w_vin     = g_stage[k-1].r_v;
      assign w_sum_acc = {w_seg_sum, g_stage[k-1].g_reg.r_sum_lo};
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_v <= 1'b0;
      end else if (w_advance) begin
        r_v <= w_vin;
      end
    end

    if (k < STAGES - 1) begin : g_reg
      logic [UPW-SEG-1:0] r_a_up;
      logic [UPW-SEG-1:0] r_b_up;
      logic [LO+SEG-1:0]  r_sum_lo;
      logic               r_c;

      // NOTE: datapath registers carry no reset; the valid bits alone decide what is live.
      always_ff @(posedge clk) begin
        if (w_advance) begin
          r_a_up   <= w_a_up[UPW-1:SEG];
          r_b_up   <= w_b_up[UPW-1:SEG];
          r_sum_lo <= w_sum_acc;
          r_c      <= w_seg_cout;
        end
      end
    end
  end

  assign w_raw_sum  = g_stage[STAGES-1].w_sum_acc;
  assign w_raw_cout = g_stage[STAGES-1].w_seg_cout;
  assign w_a_msb    = g_stage[STAGES-1].w_a_up[SEG-1];
  assign w_b_msb    = g_stage[STAGES-1].w_b_up[SEG-1];
  assign w_last_vin = g_stage[STAGES-1].w_vin;
  assign w_raw_ovf  = (w_a_msb == w_b_msb) && (w_raw_sum[WIDTH-1] != w_a_msb);

`ifdef ADDER_SAT_EN
  // NOTE: default assignment first keeps this always_comb free of inferred latches.
  always_comb begin
    w_final_sum = w_raw_sum;
    if (w_raw_ovf) begin
      w_final_sum = w_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_final_sum = w_raw_sum;
`endif

  // Result registers only load on a live result so bubbles never disturb the held output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_advance && w_last_vin) begin
      r_sum  <= w_final_sum;
      r_cout <= w_raw_cout;
      r_ovf  <= w_raw_ovf;
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
